multicycle_seq: RTL and testbench

Multi-cycle instruction sequencer for the DLX datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the enables of the shared instruction memory, data memory, ALU, PC and register file. It uses the opcode held in the instruction register. The decode control unit still produces the per-instruction datapath selects; this block decides only *when* each resource is used, retires instructions, and stops on TRAP or on a memory timeout.

---
 rtl/multicycle_seq.sv | 163 ++++++++++++++++
 tb/tb_multicycle_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq.sv
// Multi-cycle DLX instruction sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and decides when each shared resource is enabled.
module multicycle_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_wr,
  output logic        pc_inc,
  output logic        alu_en,
  output logic        pc_br_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_wr_en,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP, CL_JLINK, CL_TRAP
  } cls_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  cls_t              cls_q, cls_dec;
  logic [CNT_W-1:0]  wait_cnt;
  logic [31:0]       instret_q;
  logic              waiting;

  logic imem_req_c, ir_wr_c, pc_inc_c, alu_en_c, pc_br_en_c;
  logic dmem_req_c, dmem_we_c, rf_wr_en_c, retire_c, halted_c, fault_c;

  always_comb begin
    case (opcode)
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: cls_dec = CL_LOAD;
      6'h28, 6'h29, 6'h2b:               cls_dec = CL_STORE;
      6'h04, 6'h05:                      cls_dec = CL_BRANCH;
      6'h02, 6'h12:                      cls_dec = CL_JUMP;
      6'h03, 6'h13:                      cls_dec = CL_JLINK;
      6'h11:                             cls_dec = CL_TRAP;
      default:                           cls_dec = CL_ALU;
    endcase
  end

  assign waiting = ((state_q == S_FETCH) && !imem_ready) ||
                   ((state_q == S_MEM)   && !dmem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= CL_ALU;
      wait_cnt  <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_dec;
      // Leaving or entering a state restarts the wait count for the next one.
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + CNT_W'(1);
      instret_q <= instret_q + {31'b0, retire_c};
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req_c = 1'b0;
    ir_wr_c    = 1'b0;
    pc_inc_c   = 1'b0;
    alu_en_c   = 1'b0;
    pc_br_en_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    rf_wr_en_c = 1'b0;
    retire_c   = 1'b0;
    halted_c   = 1'b0;
    fault_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_wr_c  = 1'b1;
          pc_inc_c = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = (cls_dec == CL_TRAP) ? S_HALT : S_EXEC;
      S_EXEC: begin
        alu_en_c   = 1'b1;
        pc_br_en_c = (cls_q == CL_BRANCH) || (cls_q == CL_JUMP) || (cls_q == CL_JLINK);
        case (cls_q)
          CL_LOAD, CL_STORE:  state_d = S_MEM;
          CL_BRANCH, CL_JUMP: begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
          default:            state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (cls_q == CL_STORE);
        if (dmem_ready) begin
          if (cls_q == CL_STORE) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        rf_wr_en_c = 1'b1;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  halted_c = 1'b1;
      S_FAULT: fault_c  = 1'b1;
      default: state_d  = S_FAULT;
    endcase
  end

  // Reset is synchronous, so outputs are masked while rst is high to keep them quiet
  // during the cycle(s) before the registers have actually cleared.
  assign imem_req = imem_req_c & ~rst;
  assign ir_wr    = ir_wr_c    & ~rst;
  assign pc_inc   = pc_inc_c   & ~rst;
  assign alu_en   = alu_en_c   & ~rst;
  assign pc_br_en = pc_br_en_c & ~rst;
  assign dmem_req = dmem_req_c & ~rst;
  assign dmem_we  = dmem_we_c  & ~rst;
  assign rf_wr_en = rf_wr_en_c & ~rst;
  assign retire   = retire_c   & ~rst;
  assign halted   = halted_c   & ~rst;
  assign fault    = fault_c    & ~rst;
  assign instret  = rst ? 32'd0 : instret_q;
  assign state    = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Randomized bench for multicycle_seq: expected per-cycle traces are built from
// opcode class and memory latencies, then compared against the DUT cycle by cycle.
module tb_multicycle_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        imem_ready, dmem_ready;
  logic        imem_req, ir_wr, pc_inc, alu_en, pc_br_en;
  logic        dmem_req, dmem_we, rf_wr_en, retire, halted, fault;
  logic [31:0] instret;
  logic [2:0]  state;

  multicycle_seq #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_wr(ir_wr), .pc_inc(pc_inc), .alu_en(alu_en),
    .pc_br_en(pc_br_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_wr_en(rf_wr_en), .retire(retire), .instret(instret),
    .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] O_IMEM = 11'h400, O_IRWR = 11'h200, O_PCINC = 11'h100,
                          O_ALU  = 11'h080, O_PCBR = 11'h040, O_DREQ  = 11'h020,
                          O_DWE  = 11'h010, O_RFWR = 11'h008, O_RET   = 11'h004,
                          O_HALT = 11'h002, O_FLT  = 11'h001;
  localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3, C_J = 4, C_JL = 5, C_TRAP = 6;

  typedef struct {
    logic        r;
    logic        ir;
    logic        dr;
    logic [5:0]  op;
    logic [2:0]  st;
    logic [10:0] o;
    logic [31:0] cnt;
  } cyc_t;

  cyc_t         exp_q[$];
  logic [45:0]  obs_q[$];
  logic [31:0]  exp_instret;
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [5:0]   known_ops [0:15] = '{6'h00, 6'h01, 6'h08, 6'h20, 6'h23, 6'h25, 6'h28, 6'h2b,
                                     6'h04, 6'h05, 6'h02, 6'h12, 6'h03, 6'h13, 6'h0c, 6'h3f};

  function automatic int cls_of(input logic [5:0] op);
    if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return C_LOAD;
    if (op inside {6'h28, 6'h29, 6'h2b})               return C_STORE;
    if (op inside {6'h04, 6'h05})                      return C_BR;
    if (op inside {6'h02, 6'h12})                      return C_J;
    if (op inside {6'h03, 6'h13})                      return C_JL;
    if (op == 6'h11)                                   return C_TRAP;
    return C_ALU;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One expected cycle; the retire counter advances after any retiring cycle.
  function automatic void push(input logic r, input logic ir, input logic dr,
                               input logic [5:0] op, input logic [2:0] st, input logic [10:0] o);
    cyc_t e;
    e.r = r; e.ir = ir; e.dr = dr; e.op = op;
    e.st = r ? 3'd0 : st;
    e.o = r ? 11'd0 : o;
    e.cnt = r ? 32'd0 : exp_instret;
    if (r) exp_instret = 32'd0;
    else if ((o & O_RET) != 0) exp_instret = exp_instret + 32'd1;
    exp_q.push_back(e);
  endfunction

  function automatic void push_reset(input int n);
    for (int k = 0; k < n; k++) push(1'b1, rb(), rb(), 6'($urandom), 3'd0, 11'd0);
  endfunction

  // il / dl are the number of not-ready cycles before the ready cycle.
  function automatic void build_instr(input logic [5:0] op, input int il, input int dl);
    int c;
    logic rdy;
    c = cls_of(op);
    for (int k = 0; k <= il; k++) begin
      rdy = (k == il);
      push(1'b0, rdy, rb(), op, 3'd0, O_IMEM | (rdy ? (O_IRWR | O_PCINC) : 11'd0));
    end
    push(1'b0, rb(), rb(), op, 3'd1, 11'd0);
    if (c == C_TRAP) return;
    push(1'b0, rb(), rb(), op, 3'd2,
         O_ALU | ((c == C_BR || c == C_J || c == C_JL) ? O_PCBR : 11'd0)
               | ((c == C_BR || c == C_J) ? O_RET : 11'd0));
    if (c == C_LOAD || c == C_STORE) begin
      for (int k = 0; k <= dl; k++) begin
        rdy = (k == dl);
        push(1'b0, rb(), rdy, op, 3'd3,
             O_DREQ | ((c == C_STORE) ? O_DWE : 11'd0)
                    | ((c == C_STORE && rdy) ? O_RET : 11'd0));
      end
    end
    if (c == C_ALU || c == C_JL || c == C_LOAD) push(1'b0, rb(), rb(), op, 3'd4, O_RFWR | O_RET);
  endfunction

  // Drives the queued inputs one cycle at a time and records what the DUT shows.
  task automatic exec_queue();
    obs_q.delete();
    foreach (exp_q[i]) begin
      rst = exp_q[i].r;
      opcode = exp_q[i].op;
      imem_ready = exp_q[i].ir;
      dmem_ready = exp_q[i].dr;
      #1;
      obs_q.push_back({state, imem_req, ir_wr, pc_inc, alu_en, pc_br_en, dmem_req,
                       dmem_we, rf_wr_en, retire, halted, fault, instret});
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    exp_q.delete();
    push_reset(3);
    build_instr(6'h00, 0, 0);
    exec_queue();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== {exp_q[i].st, exp_q[i].o, exp_q[i].cnt}) begin
        n_fail++;
        $display("[TB] FAIL reset cyc%0d: got st=%0d out=%b cnt=%h, want st=%0d out=%b cnt=%h",
                 i, obs_q[i][45:43], obs_q[i][42:32], obs_q[i][31:0], exp_q[i].st, exp_q[i].o, exp_q[i].cnt);
      end
    end
  endtask

  task automatic test_classes();
    exp_q.delete();
    build_instr(6'h00, 0, 0);
    build_instr(6'h23, 0, 3);
    build_instr(6'h2b, 0, 0);
    build_instr(6'h04, 0, 0);
    build_instr(6'h03, 1, 0);
    build_instr(6'h12, 0, 0);
    build_instr(6'h21, 0, 0);
    exec_queue();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== {exp_q[i].st, exp_q[i].o, exp_q[i].cnt}) begin
        n_fail++;
        $display("[TB] FAIL classes cyc%0d: got st=%0d out=%b cnt=%h, want st=%0d out=%b cnt=%h",
                 i, obs_q[i][45:43], obs_q[i][42:32], obs_q[i][31:0], exp_q[i].st, exp_q[i].o, exp_q[i].cnt);
      end
    end
  endtask

  task automatic test_timeout();
    exp_q.delete();
    push_reset(1);
    build_instr(6'h00, 15, 0);
    build_instr(6'h28, 0, 15);
    for (int k = 0; k < 16; k++) push(1'b0, 1'b0, rb(), 6'h00, 3'd0, O_IMEM);
    for (int k = 0; k < 4; k++) push(1'b0, rb(), rb(), 6'h00, 3'd6, O_FLT);
    push_reset(1);
    build_instr(6'h2b, 0, 0);
    for (int k = 0; k < 3; k++) push(1'b0, 1'b0, rb(), 6'h2b, 3'd0, O_IMEM);
    push(1'b0, 1'b1, rb(), 6'h2b, 3'd0, O_IMEM | O_IRWR | O_PCINC);
    push(1'b0, rb(), rb(), 6'h2b, 3'd1, 11'd0);
    push(1'b0, rb(), rb(), 6'h2b, 3'd2, O_ALU);
    for (int k = 0; k < 16; k++) push(1'b0, rb(), 1'b0, 6'h2b, 3'd3, O_DREQ | O_DWE);
    for (int k = 0; k < 3; k++) push(1'b0, rb(), rb(), 6'h2b, 3'd6, O_FLT);
    push_reset(1);
    exec_queue();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== {exp_q[i].st, exp_q[i].o, exp_q[i].cnt}) begin
        n_fail++;
        $display("[TB] FAIL timeout cyc%0d: got st=%0d out=%b cnt=%h, want st=%0d out=%b cnt=%h",
                 i, obs_q[i][45:43], obs_q[i][42:32], obs_q[i][31:0], exp_q[i].st, exp_q[i].o, exp_q[i].cnt);
      end
    end
  endtask

  task automatic test_trap();
    exp_q.delete();
    push_reset(1);
    for (int k = 0; k < 5; k++) build_instr(6'h00 | 6'(k), $urandom_range(0, 2), 0);
    build_instr(6'h11, 1, 0);
    for (int k = 0; k < 6; k++) push(1'b0, rb(), rb(), 6'h11, 3'd5, O_HALT);
    push_reset(1);
    exec_queue();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== {exp_q[i].st, exp_q[i].o, exp_q[i].cnt}) begin
        n_fail++;
        $display("[TB] FAIL trap cyc%0d: got st=%0d out=%b cnt=%h, want st=%0d out=%b cnt=%h",
                 i, obs_q[i][45:43], obs_q[i][42:32], obs_q[i][31:0], exp_q[i].st, exp_q[i].o, exp_q[i].cnt);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    exp_q.delete();
    push_reset(1);
    build_instr(6'h00, 0, 0);
    push(1'b0, 1'b1, rb(), 6'h23, 3'd0, O_IMEM | O_IRWR | O_PCINC);
    push(1'b0, rb(), rb(), 6'h23, 3'd1, 11'd0);
    push(1'b0, rb(), rb(), 6'h23, 3'd2, O_ALU);
    push(1'b0, rb(), 1'b0, 6'h23, 3'd3, O_DREQ);
    push(1'b0, rb(), 1'b0, 6'h23, 3'd3, O_DREQ);
    push(1'b1, rb(), 1'b1, 6'h23, 3'd0, 11'd0);
    build_instr(6'h23, 0, 0);
    exec_queue();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== {exp_q[i].st, exp_q[i].o, exp_q[i].cnt}) begin
        n_fail++;
        $display("[TB] FAIL rst_mid_mem cyc%0d: got st=%0d out=%b cnt=%h, want st=%0d out=%b cnt=%h",
                 i, obs_q[i][45:43], obs_q[i][42:32], obs_q[i][31:0], exp_q[i].st, exp_q[i].o, exp_q[i].cnt);
      end
    end
  endtask

  task automatic test_wrap();
    // Preload the counter to all-ones while idling in FETCH with no retire.
    force dut.instret_q = 32'hFFFF_FFFF;
    rst = 1'b0;
    opcode = 6'h00;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    exp_q.delete();
    build_instr(6'h00, 0, 0);
    build_instr(6'h04, 0, 0);
    build_instr(6'h02, 0, 0);
    exec_queue();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== {exp_q[i].st, exp_q[i].o, exp_q[i].cnt}) begin
        n_fail++;
        $display("[TB] FAIL wrap cyc%0d: got st=%0d out=%b cnt=%h, want st=%0d out=%b cnt=%h",
                 i, obs_q[i][45:43], obs_q[i][42:32], obs_q[i][31:0], exp_q[i].st, exp_q[i].o, exp_q[i].cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    int il, dl;
    exp_q.delete();
    push_reset(1);
    for (int k = 0; k < 30; k++) begin
      op = ($urandom_range(0, 1) == 1) ? known_ops[$urandom_range(0, 15)] : 6'($urandom);
      if (op == 6'h11) op = 6'h01;
      il = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      dl = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      build_instr(op, il, dl);
    end
    exec_queue();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== {exp_q[i].st, exp_q[i].o, exp_q[i].cnt}) begin
        n_fail++;
        $display("[TB] FAIL back_to_back cyc%0d op=%h: got st=%0d out=%b cnt=%h, want st=%0d out=%b cnt=%h",
                 i, exp_q[i].op, obs_q[i][45:43], obs_q[i][42:32], obs_q[i][31:0], exp_q[i].st, exp_q[i].o, exp_q[i].cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = 6'h00;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    exp_instret = 32'd0;
    @(negedge clk);
    test_reset();
    test_classes();
    test_timeout();
    test_trap();
    test_reset_mid_mem();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
